// File: rtl/gate_pkg_v.sv
// gate_pkg_v: shared gate op/state encodings and the cross-beat combine helper
package gate_pkg_v;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_MAJ = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} state_e;
  function automatic logic gate_combine(op_e op, logic a, logic b);
    return op == OP_AND ? a & b : op == OP_OR ? a | b : a ^ b;
  endfunction
endpackage

// File: rtl/gate_beat_reduce_v.sv
// gate_beat_reduce_v: single-beat gate reduction plus popcount
module gate_beat_reduce_v
  import gate_pkg_v::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]           data,
  input  op_e                        op,
  output logic                       red,
  output logic [$clog2(WIDTH+1)-1:0] pop
);
  localparam int PW = $clog2(WIDTH + 1);
  assign red = op == OP_AND ? &data : op == OP_OR ? |data : ^data;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(data[i]);
  end
endmodule

// File: rtl/nary_gate_reduce_v.sv
// nary_gate_reduce_v: streaming N-input gate reduced across packet beats, one result per packet
module nary_gate_reduce_v
  import gate_pkg_v::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_BEATS = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [WIDTH-1:0]                       i_data,
  input  logic [1:0]                             i_code,
  input  logic                                   i_inv,
  input  logic                                   i_last,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  output logic                                   o_f,
  output logic [$clog2(WIDTH*MAX_BEATS+1)-1:0]   o_ones,
  output logic                                   o_err,
  output logic                                   o_valid,
  input  logic                                   i_ready
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int OW = $clog2(WIDTH * MAX_BEATS + 1);
  localparam int PW = $clog2(WIDTH + 1);
  state_e state;
  op_e op_q, op;
  logic inv_q, acc_q, first, accept, red, n_acc, maj, res, term;
  logic [PW-1:0] pop;
  logic [OW-1:0] ones_q, n_ones;
  logic [BW-1:0] beats_q, n_beats;
  assign o_ready = i_rst_n & ((state != ST_HOLD) | i_ready);
  assign accept  = i_valid & o_ready;
  // any beat accepted outside ACCUM opens a new packet
  assign first   = state != ST_ACCUM;
  assign op      = first ? op_e'(i_code) : op_q;
  gate_beat_reduce_v #(.WIDTH(WIDTH)) u_beat (.data(i_data), .op(op), .red(red), .pop(pop));
  assign n_acc   = first ? red : gate_combine(op, acc_q, red);
  assign n_ones  = (first ? '0 : ones_q) + OW'(pop);
  assign n_beats = (first ? '0 : beats_q) + BW'(1);
  assign term    = i_last | (n_beats == BW'(MAX_BEATS));
  // strict majority: ties resolve to 0
  assign maj     = (32'(n_ones) << 1) > (WIDTH * 32'(n_beats));
  assign res     = (op == OP_MAJ ? maj : n_acc) ^ (first ? i_inv : inv_q);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_AND;
      inv_q   <= 1'b0;
      acc_q   <= 1'b0;
      ones_q  <= '0;
      beats_q <= '0;
      o_f     <= 1'b0;
      o_ones  <= '0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      inv_q   <= first ? i_inv : inv_q;
      acc_q   <= n_acc;
      ones_q  <= n_ones;
      beats_q <= n_beats;
      state   <= term ? ST_HOLD : ST_ACCUM;
      o_valid <= term;
      if (term) begin
        o_f    <= res;
        o_ones <= n_ones;
        o_err  <= ~i_last;
      end
    end else if (state == ST_HOLD && i_ready) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nary_gate_reduce_v.sv
// tb_nary_gate_reduce_v: directed beats with a result scoreboard and a decoupled monitor
module tb_nary_gate_reduce_v;
  localparam int WIDTH = 3;
  localparam int MAX_BEATS = 4;
  localparam int OW = $clog2(WIDTH * MAX_BEATS + 1);
  typedef struct {
    int f;
    int ones;
    int err;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [1:0] code = 2'b00;
  logic inv = 1'b0, last = 1'b0, valid = 1'b0, rdy = 1'b1;
  logic o_ready, o_f, o_err, o_valid;
  logic [OW-1:0] o_ones;
  exp_t sb[$];
  int n_checks = 0, n_pass = 0;
  nary_gate_reduce_v #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_code(code), .i_inv(inv),
    .i_last(last), .i_valid(valid), .o_ready(o_ready), .o_f(o_f), .o_ones(o_ones),
    .o_err(o_err), .o_valid(o_valid), .i_ready(rdy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (rst_n && o_valid && rdy) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("o_f", int'(o_f), e.f);
        chk("o_ones", int'(o_ones), e.ones);
        chk("o_err", int'(o_err), e.err);
      end
    end
  end
  task automatic push(input int f, input int ones, input int err);
    exp_t e;
    e.f = f;
    e.ones = ones;
    e.err = err;
    sb.push_back(e);
  endtask
  task automatic beat(input logic [WIDTH-1:0] d, input logic [1:0] c, input logic iv, input logic l);
    logic ok;
    int tries;
    data = d;
    code = c;
    inv = iv;
    last = l;
    valid = 1'b1;
    tries = 0;
    do begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 20);
    if (!ok) chk("accept_timeout", 0, 1);
    valid = 1'b0;
    last = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #2;
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_f", int'(o_f), 0);
    chk("rst_ones", int'(o_ones), 0);
    chk("rst_err", int'(o_err), 0);
    idle(2);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", int'(o_ready), 1);
    push(1, 3, 0);
    beat(3'b111, 2'b00, 1'b0, 1'b1);
    chk("latency_1cycle", int'(o_valid), 1);
    push(0, 2, 0);
    beat(3'b110, 2'b00, 1'b0, 1'b1);
    push(0, 1, 0);
    beat(3'b000, 2'b01, 1'b1, 1'b0);
    beat(3'b000, 2'b00, 1'b0, 1'b0);
    beat(3'b001, 2'b10, 1'b0, 1'b1);
    push(1, 3, 0);
    beat(3'b011, 2'b10, 1'b0, 1'b0);
    beat(3'b001, 2'b10, 1'b0, 1'b1);
    push(0, 3, 0);
    beat(3'b110, 2'b11, 1'b0, 1'b0);
    beat(3'b100, 2'b11, 1'b0, 1'b1);
    push(1, 4, 0);
    beat(3'b111, 2'b11, 1'b0, 1'b0);
    beat(3'b100, 2'b11, 1'b0, 1'b1);
    push(1, 12, 1);
    push(0, 2, 0);
    repeat (MAX_BEATS) beat(3'b111, 2'b00, 1'b0, 1'b0);
    beat(3'b101, 2'b00, 1'b0, 1'b1);
    idle(2);
    rdy = 1'b0;
    push(1, 1, 0);
    beat(3'b100, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(o_valid), 1);
      chk("hold_f", int'(o_f), 1);
      chk("hold_ones", int'(o_ones), 1);
      chk("hold_ready", int'(o_ready), 0);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    push(1, 2, 0);
    beat(3'b011, 2'b01, 1'b0, 1'b1);
    chk("drain_accept_valid", int'(o_valid), 1);
    idle(2);
    beat(3'b111, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midpkt_rst_valid", int'(o_valid), 0);
    chk("midpkt_rst_ready", int'(o_ready), 0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    chk("no_stale_after_rst", int'(o_valid), 0);
    rdy = 1'b0;
    beat(3'b111, 2'b00, 1'b0, 1'b1);
    chk("hold_before_rst", int'(o_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", int'(o_valid), 0);
    chk("hold_rst_ones", int'(o_ones), 0);
    chk("hold_rst_f", int'(o_f), 0);
    rdy = 1'b1;
    idle(1);
    rst_n = 1'b1;
    idle(3);
    chk("no_stale_after_hold_rst", int'(o_valid), 0);
    push(1, 3, 0);
    beat(3'b111, 2'b00, 1'b0, 1'b1);
    idle(4);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
